// File: rtl/int_prio_ctrl_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM state,
// default vector layout and the source-index width helper.
package int_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  localparam logic [31:0] DEFAULT_VEC_BASE   = 32'h0000_0004;
  localparam logic [31:0] DEFAULT_VEC_STRIDE = 32'h0000_0004;
  localparam int          DEFAULT_NSRC       = 4;

  // Width of a source index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_prio_ctrl_if.sv
// CPU-side bundle of the interrupt controller: request lines, mask access,
// pipeline control and the PC redirect path.
interface int_prio_ctrl_if
  import int_pkg::*;
#(
  parameter int NSRC = DEFAULT_NSRC
);
  localparam int ID_W = id_width(NSRC);

  logic [NSRC-1:0] irq;
  logic            mask_we;
  logic [NSRC-1:0] mask_wdata;
  logic            stall;
  logic            eret;
  logic [31:0]     pc_next;
  logic [31:0]     pc;
  logic            intr;
  logic            in_service;
  logic [ID_W-1:0] irq_id;
  logic [31:0]     epc;
  logic [NSRC-1:0] mask;

  modport master (
    output irq, mask_we, mask_wdata, stall, eret, pc_next,
    input  pc, intr, in_service, irq_id, epc, mask
  );

  modport slave (
    input  irq, mask_we, mask_wdata, stall, eret, pc_next,
    output pc, intr, in_service, irq_id, epc, mask
  );

endinterface

// File: rtl/int_prio_ctrl_enc.sv
// Lowest-index-first priority encoder over the eligible request vector.
module int_prio_enc
  import int_pkg::*;
#(
  parameter int NSRC = DEFAULT_NSRC,
  localparam int ID_W = id_width(NSRC)
) (
  input  logic [NSRC-1:0] eligible,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scan downward so the lowest set index is the last assignment and wins.
  always_comb begin
    valid = |eligible;
    id    = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/int_prio_ctrl.sv
// Fixed-priority vectored interrupt controller between PC-next logic and the
// PC register: edge-detected requests, mask, single-level service with eret.
module int_prio_ctrl
  import int_pkg::*;
#(
  parameter int          NSRC       = DEFAULT_NSRC,
  parameter logic [31:0] VEC_BASE   = DEFAULT_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEFAULT_VEC_STRIDE
) (
  input  logic          clk,
  input  logic          rst,
  int_prio_ctrl_if.slave bus
);

  localparam int ID_W = id_width(NSRC);

  logic [NSRC-1:0] irq_q_reg;
  logic [NSRC-1:0] pending_reg;
  logic [NSRC-1:0] mask_reg;
  state_t          state_reg;
  logic [31:0]     epc_reg;
  logic [ID_W-1:0] irq_id_reg;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] take_clr;
  logic [NSRC-1:0] pending_next;
  logic            any_eligible;
  logic [ID_W-1:0] winner;
  logic            take;
  logic [31:0]     vec_addr;

  assign rise     = bus.irq & ~irq_q_reg;
  assign eligible = pending_reg & ~mask_reg;

  int_prio_enc #(
    .NSRC (NSRC)
  ) u_enc (
    .eligible (eligible),
    .valid    (any_eligible),
    .id       (winner)
  );

  assign take     = (state_reg == IDLE) & any_eligible & ~bus.stall & ~rst;
  assign vec_addr = VEC_BASE + (32'(winner) * VEC_STRIDE);
  assign take_clr = take ? (NSRC'(1) << winner) : '0;
  // A fresh edge on the winning source in its take cycle keeps the bit set.
  assign pending_next = (pending_reg & ~take_clr) | rise;

  always_comb begin
    if (rst) begin
      bus.pc = 32'h0;
    end else if (take) begin
      bus.pc = vec_addr;
    end else if ((state_reg == SERVICE) && bus.eret) begin
      bus.pc = epc_reg;
    end else begin
      bus.pc = bus.pc_next;
    end
  end

  always_ff @(posedge clk) begin
    irq_q_reg <= bus.irq;
    if (rst) begin
      pending_reg <= '0;
      mask_reg    <= '0;
      state_reg   <= IDLE;
      epc_reg     <= 32'h0;
      irq_id_reg  <= '0;
    end else begin
      pending_reg <= pending_next;
      if (bus.mask_we) mask_reg <= bus.mask_wdata;
      case (state_reg)
        IDLE: begin
          if (take) begin
            epc_reg    <= bus.pc_next;
            irq_id_reg <= winner;
            state_reg  <= SERVICE;
          end
        end
        SERVICE: begin
          if (bus.eret) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.intr       = any_eligible;
  assign bus.in_service = (state_reg == SERVICE);
  assign bus.irq_id     = irq_id_reg;
  assign bus.epc        = epc_reg;
  assign bus.mask       = mask_reg;

endmodule

// File: doc/int_prio_ctrl.md
Name: int_prio_ctrl

Overview:
- Multi-source, fixed-priority, vectored interrupt controller for the 5-stage pipeline CPU.
- Edge-detects NSRC external interrupt lines, latches pending requests and applies a software-written mask.
- Selects the highest-priority unmasked request and redirects the fetch PC to a per-source vector, saving the return PC.
- Blocks further interrupts until eret, then restores the saved PC. Sits between the PC-next logic and the PC register.

Parameters:
- NSRC, 4, number of interrupt sources (2..16).
- VEC_BASE, 32'h00000004, vector address of source 0.
- VEC_STRIDE, 32'h00000004, address spacing between consecutive source vectors.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- irq  in  NSRC  interrupt lines, synchronous to clk; a rising edge requests service.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NSRC  new mask value; bit=1 blocks that source.
- stall  in  1  pipeline stall; no interrupt may be taken while high.
- eret  in  1  return-from-interrupt, from decode.
- pc_next  in  32  sequential/branch next PC from the datapath.
- pc  out  32  selected next PC (combinational).
- intr  out  1  any pending and unmasked request (combinational).
- in_service  out  1  a handler is active.
- irq_id  out  $clog2(NSRC)  index of the source being serviced (registered).
- epc  out  32  saved return PC (registered).
- mask  out  NSRC  current mask register.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - pending=0, mask=0, state=IDLE, epc=0, irq_id=0.
  - irq_q<=irq, so lines held high across reset do not generate a request.
  - pc=0 combinationally whenever rst=1.
- Edge detection: rise = irq & ~irq_q; irq_q<=irq every cycle.
- Pending:
  - A rising edge sets its bit even when masked.
  - A bit clears only when its source is taken.
  - If a new edge arrives on the winning source in its take cycle, the set wins and the bit stays 1.
- Mask: mask_we loads mask_wdata at the edge. A mask change affects the take decision from the next cycle.
- Arbitration: eligible = pending & ~mask. Winner is the lowest index set in eligible. intr = |eligible.
- take = (state==IDLE) & intr & ~stall & ~rst.
- FSM, 2 states:
  - IDLE:
    - On take: epc<=pc_next, irq_id<=winner, clear pending[winner], go to SERVICE.
    - On eret without take: ignored; pc=pc_next.
  - SERVICE:
    - No takes; in_service=1.
    - On eret: go to IDLE; pc=epc in that cycle.
    - Pending still accumulates and the mask is still writable.
- PC mux priority: rst -> 0; take -> VEC_BASE + winner*VEC_STRIDE (32-bit, wraps modulo 2^32); SERVICE&eret -> epc; else pc_next.
- Latency: edge sampled at edge N sets pending; the earliest take is cycle N+1 (redirect visible combinationally in that cycle).
- Back-to-back: the eret cycle cannot also take. The earliest new take is the cycle after eret.
- Stall: a take is deferred while stall=1 and the request remains pending. eret is honoured regardless of stall.
- Nesting is not supported. irq_id and epc hold their values until the next take.
- Reset mid-service returns to IDLE and drops all pending requests.

Decomposition:
- Shared package int_pkg holds:
  - state enum (IDLE=1'b0, SERVICE=1'b1);
  - default VEC_BASE/VEC_STRIDE constants;
  - NSRC-derived id width.
- One sub-module, int_prio_enc: combinational lowest-index-first priority encoder, eligible[NSRC] -> {valid, id}.
- Everything else lives in the top module.

Test Plan:
- Reset release with irq=4'b0010 held high -> no pending bit, intr=0, pc=pc_next, mask=0, epc=0.
- Single edge on irq[2], pc_next=0x100 -> next cycle pc=0x0C, then epc=0x100, irq_id=2, in_service=1; a later eret gives pc=0x100, in_service=0.
- Simultaneous edges on irq[3] and irq[1] -> source 1 taken first (pc=0x08); after eret plus one cycle, source 3 taken (pc=0x10).
- mask=4'b0001 and edge on irq[0] -> intr=0, no take; writing mask=0 -> take on the following cycle, pc=0x04.
- Edge on irq[1] while stall=1 for 3 cycles -> pc=pc_next throughout and pending kept; take on the first cycle with stall=0.
- Edge on irq[0] during SERVICE, then rst pulse -> state IDLE, pending=0, pc=0 during rst; eret in IDLE afterwards is ignored, pc=pc_next.
